div_sequencer: RTL

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer.sv | 82 ++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle unsigned restoring divider, one quotient bit per clock,
// with registered quotient, remainder and {N,Z,C,V} flags.
module div_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] y,
  output logic [N-1:0] mod,
  output logic [3:0]   f
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  dq, dv, q_nx;
  logic [N:0]    rem, rem_sh, rem_nx;
  logic          ge;
  // dq shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    rem_sh = {rem[N-1:0], dq[N-1]};
    ge     = rem_sh >= {1'b0, dv};
    rem_nx = ge ? rem_sh - {1'b0, dv} : rem_sh;
    q_nx   = {dq[N-2:0], ge};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      y     <= '0;
      mod   <= '0;
      f     <= '0;
      cnt   <= '0;
      dq    <= '0;
      dv    <= '0;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (b != '0) begin
            dq    <= a;
            dv    <= b;
            rem   <= '0;
            cnt   <= '0;
            state <= CALC;
          end else begin
            y     <= '1;
            mod   <= a;
            f     <= 4'b1001;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        CALC: begin
          dq  <= q_nx;
          rem <= rem_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            y     <= q_nx;
            mod   <= rem_nx[N-1:0];
            f     <= {q_nx[N-1], q_nx == '0, 2'b00};
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
